vs10xx_spi_ctrl: RTL

Parametrised SPI master for the VS10xx audio decoder. It replaces the hard-coded command list and bit-banged player loop with two valid/ready streams: an SCI command port (register write and read) and an SDI data port. The block sits between the song/volume control logic and the decoder pins. It owns the hardware-reset sequence, SCLK generation, DREQ flow control and command-over-data arbitration.

---
 rtl/vs10xx_spi_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/vs10xx_spi_ctrl.sv
// SPI master for a VS10xx decoder: runs the hardware-reset sequence, then serves an SCI
// command stream and an SDI data stream over one mode-0 bus, commands taking priority.
module vs10xx_spi_ctrl #(
    parameter int CLK_DIV  = 50,
    parameter int DATA_W   = 32,
    parameter int RST_HOLD = 100,
    parameter int RST_WAIT = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              restart,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [7:0]        cmd_addr,
    input  logic [15:0]       cmd_wdata,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              MP3_RST,
    output logic              MP3_CS,
    output logic              MP3_DCS,
    output logic              MP3_MOSI,
    output logic              MP3_SCLK,
    input  logic              MP3_MISO,
    input  logic              MP3_DREQ
);

    // Shift register is wide enough for a 32-bit SCI frame or a full SDI word, MSB-aligned.
    localparam int          SR_W      = (DATA_W > 32) ? DATA_W : 32;
    localparam logic [31:0] HALF_LAST = 32'(CLK_DIV - 1);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0] WAIT_LAST = 32'(RST_WAIT - 1);

    typedef enum logic [2:0] {
        ST_RESET_HOLD,
        ST_RESET_WAIT,
        ST_IDLE,
        ST_SCI_SHIFT,
        ST_SDI_SHIFT,
        ST_GUARD
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       cnt_reg, cnt_next;
    logic [6:0]        bit_reg, bit_next;
    logic [SR_W-1:0]   sr_reg, sr_next;
    logic [15:0]       miso_sr_reg, miso_sr_next;
    logic              rd_op_reg, rd_op_next;
    logic              sclk_reg, sclk_next;
    logic              cs_reg, cs_next;
    logic              dcs_reg, dcs_next;
    logic              mosi_reg, mosi_next;
    logic              mp3_rst_reg, mp3_rst_next;
    logic [15:0]       rd_data_reg, rd_data_next;
    logic              rd_valid_reg, rd_valid_next;

    logic [1:0]        meta_reg, sync_reg;
    logic              dreq_s, miso_s;
    logic              cmd_hs, data_hs;
    logic [31:0]       sci_word;
    logic [6:0]        last_bit;

    // Bit 1 carries DREQ, bit 0 carries MISO.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_reg <= 2'b00;
            sync_reg <= 2'b00;
        end else begin
            meta_reg <= {MP3_DREQ, MP3_MISO};
            sync_reg <= meta_reg;
        end
    end
    assign dreq_s = sync_reg[1];
    assign miso_s = sync_reg[0];

    assign cmd_ready  = (state_reg == ST_IDLE) && dreq_s;
    assign data_ready = cmd_ready && !cmd_valid;
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign data_hs    = data_valid && data_ready;
    assign busy       = (state_reg != ST_IDLE);

    assign sci_word = {(cmd_rd ? 8'h03 : 8'h02), cmd_addr, (cmd_rd ? 16'h0000 : cmd_wdata)};
    assign last_bit = (state_reg == ST_SCI_SHIFT) ? 7'd31 : 7'(DATA_W - 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_RESET_HOLD;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            sr_reg       <= '0;
            miso_sr_reg  <= '0;
            rd_op_reg    <= 1'b0;
            sclk_reg     <= 1'b0;
            cs_reg       <= 1'b1;
            dcs_reg      <= 1'b1;
            mosi_reg     <= 1'b0;
            mp3_rst_reg  <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            sr_reg       <= sr_next;
            miso_sr_reg  <= miso_sr_next;
            rd_op_reg    <= rd_op_next;
            sclk_reg     <= sclk_next;
            cs_reg       <= cs_next;
            dcs_reg      <= dcs_next;
            mosi_reg     <= mosi_next;
            mp3_rst_reg  <= mp3_rst_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        sr_next       = sr_reg;
        miso_sr_next  = miso_sr_reg;
        rd_op_next    = rd_op_reg;
        sclk_next     = sclk_reg;
        cs_next       = cs_reg;
        dcs_next      = dcs_reg;
        mosi_next     = mosi_reg;
        mp3_rst_next  = mp3_rst_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;

        case (state_reg)
            ST_RESET_HOLD: begin
                mp3_rst_next = 1'b0;
                if (cnt_reg == HOLD_LAST) begin
                    state_next   = ST_RESET_WAIT;
                    cnt_next     = '0;
                    mp3_rst_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_RESET_WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (cmd_hs) begin
                    sr_next    = SR_W'(sci_word) << (SR_W - 32);
                    mosi_next  = sci_word[31];
                    rd_op_next = cmd_rd;
                    cs_next    = 1'b0;
                    state_next = ST_SCI_SHIFT;
                end else if (data_hs) begin
                    sr_next    = SR_W'(data_in) << (SR_W - DATA_W);
                    mosi_next  = data_in[DATA_W-1];
                    rd_op_next = 1'b0;
                    dcs_next   = 1'b0;
                    state_next = ST_SDI_SHIFT;
                end
            end
            ST_SCI_SHIFT, ST_SDI_SHIFT: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                        // Only the data half of a read frame carries MISO payload.
                        if (state_reg == ST_SCI_SHIFT && rd_op_reg && bit_reg >= 7'd16)
                            miso_sr_next = {miso_sr_reg[14:0], miso_s};
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg == last_bit) begin
                            state_next = ST_GUARD;
                            cs_next    = 1'b1;
                            dcs_next   = 1'b1;
                            if (state_reg == ST_SCI_SHIFT && rd_op_reg) begin
                                rd_data_next  = miso_sr_reg;
                                rd_valid_next = 1'b1;
                            end
                        end else begin
                            bit_next  = bit_reg + 7'd1;
                            sr_next   = sr_reg << 1;
                            mosi_next = sr_reg[SR_W-2];
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_GUARD: begin
                if (cnt_reg == HALF_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            default: begin
                state_next = ST_RESET_HOLD;
                cnt_next   = '0;
            end
        endcase

        // Abort wins over everything, including a read completing this cycle.
        if (restart) begin
            state_next    = ST_RESET_HOLD;
            cnt_next      = '0;
            bit_next      = '0;
            sclk_next     = 1'b0;
            cs_next       = 1'b1;
            dcs_next      = 1'b1;
            mosi_next     = 1'b0;
            mp3_rst_next  = 1'b0;
            rd_valid_next = 1'b0;
        end
    end

    assign MP3_RST  = mp3_rst_reg;
    assign MP3_CS   = cs_reg;
    assign MP3_DCS  = dcs_reg;
    assign MP3_MOSI = mosi_reg;
    assign MP3_SCLK = sclk_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule
